// File: rtl/time_counter_if.sv
// Control inputs and BCD time outputs of the timekeeping stage.
// The master side drives mode/edit controls; the slave side (the counter) drives sec_tick and digits.
interface time_counter_if;
    logic       set_mode;
    logic [1:0] field_sel;
    logic       inc;
    logic       sec_tick;
    logic [3:0] hour1;
    logic [3:0] hour0;
    logic [3:0] minute1;
    logic [3:0] minute0;
    logic [3:0] second1;
    logic [3:0] second0;

    modport master (
        output set_mode, field_sel, inc,
        input  sec_tick, hour1, hour0, minute1, minute0, second1, second0
    );

    modport slave (
        input  set_mode, field_sel, inc,
        output sec_tick, hour1, hour0, minute1, minute0, second1, second0
    );
endinterface

// File: rtl/time_counter.sv
// 1 Hz prescaler plus HH:MM:SS BCD counter with a freeze-and-edit SET mode.
// Latency: all outputs registered, one edge from tick/inc to new digits; no backpressure.
module time_counter #(
    parameter int TICK_DIV = 25_000_000,
    parameter int CNT_W    = 25
) (
    input  logic          clk,
    input  logic          rst_n,
    time_counter_if.slave bus
);

    typedef enum logic {ST_RUN, ST_SET} state_e;

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d;
    logic [3:0]       h1_q, h0_q, m1_q, m0_q, s1_q, s0_q;
    logic [3:0]       h1_d, h0_d, m1_d, m0_d, s1_d, s0_d;
    logic [8:0]       sec_n, min_n;
    logic [7:0]       hr_n;

    // Returns {carry, tens, units}; an out-of-range field restarts at 00 without carry.
    function automatic logic [8:0] inc_ms(input logic [3:0] t, input logic [3:0] u);
        if (t > 4'd5 || u > 4'd9) return 9'd0;
        if (u != 4'd9)            return {1'b0, t, u + 4'd1};
        if (t != 4'd5)            return {1'b0, t + 4'd1, 4'd0};
        return {1'b1, 8'd0};
    endfunction

    function automatic logic [7:0] inc_hr(input logic [3:0] t, input logic [3:0] u);
        logic legal;
        legal = (t < 4'd2 && u <= 4'd9) || (t == 4'd2 && u <= 4'd3);
        if (!legal || (t == 4'd2 && u == 4'd3)) return 8'h00;
        if (u == 4'd9)                           return {t + 4'd1, 4'd0};
        return {t, u + 4'd1};
    endfunction

    assign sec_n = inc_ms(s1_q, s0_q);
    assign min_n = inc_ms(m1_q, m0_q);
    assign hr_n  = inc_hr(h1_q, h0_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            presc_q <= '0;
            tick_q  <= 1'b0;
            h1_q    <= 4'd0;
            h0_q    <= 4'd0;
            m1_q    <= 4'd0;
            m0_q    <= 4'd0;
            s1_q    <= 4'd0;
            s0_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            h1_q    <= h1_d;
            h0_q    <= h0_d;
            m1_q    <= m1_d;
            m0_q    <= m0_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
        end
    end

    always_comb begin
        state_d = bus.set_mode ? ST_SET : ST_RUN;
        presc_d = presc_q;
        tick_d  = 1'b0;
        h1_d    = h1_q;
        h0_d    = h0_q;
        m1_d    = m1_q;
        m0_d    = m0_q;
        s1_d    = s1_q;
        s0_d    = s0_q;

        // set_mode is looked at directly so that entering SET beats a pending tick.
        if (bus.set_mode) begin
            presc_d = '0;
            if (state_q == ST_SET && bus.inc) begin
                case (bus.field_sel)
                    2'd0:    {s1_d, s0_d} = sec_n[7:0];
                    2'd1:    {m1_d, m0_d} = min_n[7:0];
                    2'd2:    {h1_d, h0_d} = hr_n;
                    default: ;
                endcase
            end
        end else if (presc_q == PRESC_LAST) begin
            presc_d      = '0;
            tick_d       = 1'b1;
            {s1_d, s0_d} = sec_n[7:0];
            if (sec_n[8]) begin
                {m1_d, m0_d} = min_n[7:0];
                if (min_n[8]) begin
                    {h1_d, h0_d} = hr_n;
                end
            end
        end else begin
            presc_d = presc_q + CNT_W'(1);
        end
    end

    assign bus.sec_tick = tick_q;
    assign bus.hour1    = h1_q;
    assign bus.hour0    = h0_q;
    assign bus.minute1  = m1_q;
    assign bus.minute0  = m0_q;
    assign bus.second1  = s1_q;
    assign bus.second0  = s0_q;

endmodule

// File: tb/tb_time_counter.sv
// Scoreboarded bench for time_counter with TICK_DIV=4: stimulus queues expected (cycle, sec_tick, HHMMSS)
// entries, the monitor compares them on the falling edge and flags any sec_tick nobody expected.
module tb_time_counter;

    logic clk = 1'b0;
    logic rst_n;

    time_counter_if tc_if ();

    time_counter #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tc_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        tick;
        logic [23:0] tm;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   done   = 1'b0;

    logic [23:0] now_tm;
    assign now_tm = {tc_if.hour1, tc_if.hour0, tc_if.minute1, tc_if.minute0,
                     tc_if.second1, tc_if.second0};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_exp(int off, logic tk, logic [23:0] tm, string nm);
        exp_t e;
        e.cyc  = cyc + off;
        e.tick = tk;
        e.tm   = tm;
        e.name = nm;
        exp_q.push_back(e);
    endfunction

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: consumes expectations due this cycle and watches for stray ticks.
    always @(negedge clk) begin
        exp_t e;
        bit   tick_ok;
        tick_ok = 1'b0;
        while (exp_q.size() > 0 && (exp_q[0].cyc <= cyc || done)) begin
            e = exp_q.pop_front();
            n_chk++;
            if (e.cyc != cyc) begin
                $display("FAIL %s: expectation for cycle %0d unchecked, now cycle %0d", e.name, e.cyc, cyc);
            end else if (tc_if.sec_tick !== e.tick || now_tm !== e.tm) begin
                $display("FAIL %s: cycle %0d got tick=%0b time=%06h, want tick=%0b time=%06h",
                         e.name, cyc, tc_if.sec_tick, now_tm, e.tick, e.tm);
            end else begin
                n_pass++;
            end
            if (e.tick) tick_ok = 1'b1;
        end
        if (tc_if.sec_tick !== 1'b0 && !tick_ok) begin
            n_chk++;
            $display("FAIL stray_tick: cycle %0d got sec_tick=%0b time=%06h, want sec_tick=0",
                     cyc, tc_if.sec_tick, now_tm);
        end
    end

    initial begin
        rst_n           = 1'b0;
        tc_if.set_mode  = 1'b0;
        tc_if.field_sel = 2'd3;
        tc_if.inc       = 1'b0;

        // Reset and first tick after release.
        step(1);
        push_exp(0, 1'b0, 24'h000000, "rst_hold");
        step(1);
        rst_n = 1'b1;
        push_exp(3, 1'b0, 24'h000000, "pre_first_tick");
        push_exp(4, 1'b1, 24'h000001, "first_tick");
        push_exp(5, 1'b0, 24'h000001, "tick_drops");
        step(6);

        // Asynchronous reset mid-run, prescaler at 2.
        rst_n = 1'b0;
        push_exp(0, 1'b0, 24'h000000, "async_rst");
        step(2);
        rst_n = 1'b1;
        push_exp(3, 1'b0, 24'h000000, "rerelease_wait");
        push_exp(4, 1'b1, 24'h000001, "rerelease_tick");
        step(4);

        // SET: hours stepped 25 times wraps through 23 -> 00 -> 01.
        tc_if.set_mode = 1'b1;
        step(1);
        tc_if.field_sel = 2'd2;
        tc_if.inc       = 1'b1;
        push_exp(23, 1'b0, 24'h230001, "hours_23");
        push_exp(24, 1'b0, 24'h000001, "hours_wrap");
        push_exp(25, 1'b0, 24'h010001, "hours_01");
        step(25);
        tc_if.field_sel = 2'd1;
        push_exp(59, 1'b0, 24'h015901, "minutes_59");
        push_exp(60, 1'b0, 24'h010001, "minutes_wrap_no_carry");
        step(60);
        tc_if.field_sel = 2'd3;
        push_exp(3, 1'b0, 24'h010001, "field_none");
        step(3);
        tc_if.field_sel = 2'd0;
        push_exp(58, 1'b0, 24'h010059, "seconds_59");
        push_exp(59, 1'b0, 24'h010000, "seconds_wrap_no_carry");
        step(59);

        // Preset 00:59:58, then run with inc held high (must be ignored).
        tc_if.field_sel = 2'd2;
        step(23);
        tc_if.field_sel = 2'd1;
        step(59);
        tc_if.field_sel = 2'd0;
        step(58);
        push_exp(0, 1'b0, 24'h005958, "preset_ripple");
        tc_if.set_mode = 1'b0;
        push_exp(3, 1'b0, 24'h005958, "run_restart_wait");
        push_exp(4, 1'b1, 24'h005959, "ripple_59");
        push_exp(5, 1'b0, 24'h005959, "inc_in_run_ignored");
        push_exp(8, 1'b1, 24'h010000, "ripple_to_hour");
        push_exp(9, 1'b0, 24'h010000, "ripple_hold");
        step(8);
        tc_if.inc       = 1'b0;
        tc_if.field_sel = 2'd3;

        // Freeze with prescaler at 2 for 100 cycles.
        step(2);
        tc_if.set_mode = 1'b1;
        push_exp(1, 1'b0, 24'h010000, "freeze_start");
        push_exp(50, 1'b0, 24'h010000, "freeze_mid");
        push_exp(100, 1'b0, 24'h010000, "freeze_end");
        step(100);

        // Preset 23:59:59.
        tc_if.field_sel = 2'd2;
        tc_if.inc       = 1'b1;
        step(22);
        tc_if.field_sel = 2'd1;
        step(59);
        tc_if.field_sel = 2'd0;
        step(59);
        tc_if.inc       = 1'b0;
        tc_if.field_sel = 2'd3;
        push_exp(0, 1'b0, 24'h235959, "preset_daywrap");

        // SET raised on the prescaler=3 cycle must suppress the advance.
        tc_if.set_mode = 1'b0;
        step(3);
        tc_if.set_mode = 1'b1;
        push_exp(1, 1'b0, 24'h235959, "collision_no_advance");
        push_exp(5, 1'b0, 24'h235959, "collision_hold");
        step(5);
        tc_if.set_mode = 1'b0;
        push_exp(3, 1'b0, 24'h235959, "daywrap_wait");
        push_exp(4, 1'b1, 24'h000000, "day_wrap");
        push_exp(5, 1'b0, 24'h000000, "day_wrap_one_cycle");
        step(6);

        done = 1'b1;
        step(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/time_counter.md
# time_counter

Upstream timekeeping stage of the digital clock: divides the system clock into a 1 Hz tick and maintains hours, minutes and seconds as six BCD digits. Its digit outputs feed the hourly-chime stage and the display driver. A set mode freezes time and lets the user step hours, minutes or seconds with single-cycle increment pulses from the (already debounced) button logic.

## Interface
- TICK_DIV, 25_000_000, system clock cycles per second (25 MHz clock); must be ≥ 2
- CNT_W, 25, prescaler counter width; must hold TICK_DIV-1
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- set_mode  in  1  1 = SET state (time frozen, editing allowed), 0 = RUN
- field_sel  in  2  field to edit in SET: 0 seconds, 1 minutes, 2 hours, 3 none
- inc  in  1  single-cycle increment request, meaningful only in SET
- sec_tick  out  1  one-cycle pulse on the cycle the time advances by one second
- hour1, hour0  out  4  BCD hours tens (0-2) / units (0-9, 0-3 when hour1=2)
- minute1, minute0  out  4  BCD minutes tens (0-5) / units (0-9)
- second1, second0  out  4  BCD seconds tens (0-5) / units (0-9)

## Operation
- Two states: RUN and SET. State register follows set_mode with one cycle of registration; reset state RUN.
- RUN: prescaler counts 0 to TICK_DIV-1 and wraps. When prescaler = TICK_DIV-1, the next edge advances time by one second and asserts sec_tick for exactly that one cycle.
- Advance is a BCD ripple: second0 9→0 carries into second1; second1 5→0 carries into minute0; minute0 9→0 into minute1; minute1 5→0 into hour0; hour0 9→0 into hour1; 23:59:59 → 00:00:00 (hour0 3→0 and hour1 2→0 together).
- SET: prescaler held at 0, sec_tick held 0, digits do not advance. Each inc pulse increments the selected field by one with wrap inside that field only, with no carry into the next field: seconds 59→00, minutes 59→00, hours 23→00. field_sel=3: inc ignored.
- inc in RUN is ignored. inc held high for N cycles in SET gives N increments.
- SET→RUN: prescaler restarts from 0, so the first sec_tick comes TICK_DIV cycles after the first RUN cycle.
- Digits never hold a non-BCD or out-of-range value. Any illegal value that somehow appears (e.g. an SEU) is cleared to 0 on that field's next update.

## Timing
- Reset (async assert, synchronous-release behaviour): all digits 0 (00:00:00), prescaler 0, sec_tick 0, state RUN. Outputs go to these values immediately on rst_n low.
- All outputs are registered, with no combinational path from inputs to outputs.
- sec_tick and the new digit values appear in the same cycle: the cycle after prescaler = TICK_DIV-1.
- inc sampled at edge k in SET: new field value is visible after edge k.
- set_mode rising in the same cycle as prescaler = TICK_DIV-1: SET wins. No advance, no sec_tick, prescaler cleared.
- set_mode falling: the RUN count starts on the next edge. An inc in that same cycle is ignored.
- Reset asserted mid-increment or mid-ripple: all fields go to 0. A partial carry is never visible.
- Downstream chime stage reads the digits combinationally. Digits change only on clock edges, one edge per second in RUN.

## Test plan
- Reset: TICK_DIV=4, pulse rst_n low mid-run → all digits 0, sec_tick 0 at once. First sec_tick appears 4 cycles after release, with second0=1.
- Ripple: preset 00:59:58 via SET, then RUN with TICK_DIV=4 → 00:59:59, then 01:00:00 after 4 more cycles. The 59:56-59:58 and 00:00 chime windows can be checked against the chime stage.
- Day wrap: preset 23:59:59, run one tick → 00:00:00, sec_tick one cycle high.
- Set fields: SET, field_sel=2, 25 inc pulses from 00 → hours=01 with minutes and seconds unchanged. field_sel=1, 60 pulses → minutes back to the start value with no hour carry. field_sel=3, inc → no change.
- Freeze and restart: enter SET at prescaler=2 → digits frozen for 100 cycles, sec_tick 0. Leave SET → next sec_tick exactly TICK_DIV cycles later.
- Collisions: set_mode rises on the prescaler=TICK_DIV-1 cycle → no advance, no sec_tick. inc in RUN → ignored.
